// File: rtl/find_best_hop_if.sv
// Bus bundle between find_best_hop and its surroundings: scan control,
// node identity inputs, the shared data-memory read port and the results.
interface find_best_hop_if;
   logic        start;
   logic [15:0] my_id;
   logic [15:0] my_cluster;
   logic [15:0] my_q;
   logic [7:0]  neighbor_count;
   logic [15:0] data_in;
   logic [10:0] address;
   logic [15:0] nexthop;
   logic [15:0] nextsinks;
   logic [15:0] best_q;
   logic        busy;
   logic        done;

   modport master (
      output start, my_id, my_cluster, my_q, neighbor_count, data_in,
      input  address, nexthop, nextsinks, best_q, busy, done
   );

   modport slave (
      input  start, my_id, my_cluster, my_q, neighbor_count, data_in,
      output address, nexthop, nextsinks, best_q, busy, done
   );
endinterface

// File: rtl/find_best_hop.sv
// find_best_hop: scans the neighbour table in shared data memory and reports
// the best-Q neighbour above the node's own Q (nexthop/best_q) and the first
// in-cluster sink (nextsinks). Memory read data arrives two edges after the
// address is registered, so a two-deep valid/word-select pipeline follows
// each address into the capture stage.
module find_best_hop #(
   parameter logic [10:0] NBR_BASE = 11'h010,
   parameter int          MAX_NBR  = 32,
   parameter logic [15:0] NONE_ID  = 16'd65
) (
   input logic            clock,
   input logic            rst,
   find_best_hop_if.slave bus
);

   localparam int CNT_W = $clog2(4 * MAX_NBR);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DRAIN,
      S_FINISH
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             go;
   logic [CNT_W-1:0] wcnt_q;
   logic [CNT_W-1:0] last_q;
   logic             drain_q;

   logic             vld_p0;
   logic             vld_p1;
   logic [1:0]       wsel_p0;
   logic [1:0]       wsel_p1;
   logic [15:0]      id_p2;
   logic [15:0]      cl_p2;
   logic [15:0]      q_p2;

   logic             role_cap;
   logic             ent_ok;
   logic             hop_win;
   logic             sink_win;

   // Index of the last word to read: 4*min(count, MAX_NBR) - 1.
   function automatic logic [CNT_W-1:0] last_word(input logic [7:0] cnt);
      int n;
      n = (int'(cnt) > MAX_NBR) ? MAX_NBR : int'(cnt);
      return CNT_W'(4 * n - 1);
   endfunction

   // Next-state logic; go marks an accepted start in IDLE.
   always_comb begin
      state_d = state_q;
      go      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               go      = 1'b1;
               state_d = (bus.neighbor_count == 8'd0) ? S_FINISH : S_SCAN;
            end
         end
         S_SCAN:   if (wcnt_q == last_q) state_d = S_DRAIN;
         S_DRAIN:  if (drain_q) state_d = S_FINISH;
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Entry evaluation, done on the edge that captures the role word.
   always_comb begin
      role_cap = vld_p1 && (wsel_p1 == 2'd3);
      ent_ok   = (id_p2 != NONE_ID) && (id_p2 != bus.my_id);
      hop_win  = role_cap && ent_ok && (q_p2 > bus.my_q) && (q_p2 > bus.best_q);
      sink_win = role_cap && ent_ok && (bus.nextsinks == NONE_ID) &&
                 (cl_p2 == bus.my_cluster) && bus.data_in[0];
   end

   // Word-select pipeline and per-entry field capture (data only, no reset).
   always_ff @(posedge clock) begin
      // p0: word select of the address driven this edge
      wsel_p0 <= wcnt_q[1:0];
      // p1: memory is producing that word
      wsel_p1 <= wsel_p0;
      // p2: word lands on data_in and is captured
      if (vld_p1) begin
         case (wsel_p1)
            2'd0:    id_p2 <= bus.data_in;
            2'd1:    cl_p2 <= bus.data_in;
            2'd2:    q_p2  <= bus.data_in;
            default: ;
         endcase
      end
      if (go) last_q <= last_word(bus.neighbor_count);
   end

   // Address generation, valid pipeline, results and status flags.
   always_ff @(posedge clock) begin
      if (rst) begin
         bus.address   <= 11'd0;
         bus.nexthop   <= NONE_ID;
         bus.nextsinks <= NONE_ID;
         bus.best_q    <= 16'd0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         wcnt_q        <= '0;
         drain_q       <= 1'b0;
         vld_p0        <= 1'b0;
         vld_p1        <= 1'b0;
      end else begin
         vld_p0  <= (state_q == S_SCAN);
         vld_p1  <= vld_p0;
         drain_q <= (state_q == S_DRAIN) && !drain_q;
         if (go) begin
            bus.busy      <= 1'b1;
            bus.done      <= 1'b0;
            bus.nexthop   <= NONE_ID;
            bus.nextsinks <= NONE_ID;
            bus.best_q    <= 16'd0;
            wcnt_q        <= '0;
         end
         if (state_q == S_SCAN) begin
            bus.address <= NBR_BASE + 11'(wcnt_q);
            wcnt_q      <= wcnt_q + 1'b1;
         end
         if (state_q == S_FINISH) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
         end
         if (hop_win) begin
            bus.nexthop <= id_p2;
            bus.best_q  <= q_p2;
         end
         if (sink_win) bus.nextsinks <= id_p2;
      end
   end

endmodule

// File: tb/tb_find_best_hop.sv
// Bench for find_best_hop: a one-cycle-latency memory model feeds data_in,
// a reference model pushes expected results into a scoreboard when a scan
// is launched, and each test pops and compares when done rises.
module tb_find_best_hop;
   localparam logic [10:0] NBR_BASE = 11'h010;
   localparam int          MAX_NBR  = 32;
   localparam logic [15:0] NONE_ID  = 16'd65;
   localparam int          MAXC     = 400;

   typedef struct {
      logic [15:0] nh;
      logic [15:0] ns;
      logic [15:0] bq;
      int          lat;
   } exp_t;

   logic clock = 1'b0;
   logic rst   = 1'b1;
   logic [15:0] mem [0:2047];
   exp_t sb[$];
   exp_t e;
   int checks   = 0;
   int failures = 0;
   int obs_lat, obs_steps, obs_jumps;
   logic obs_timeout, obs_busy_all;
   logic [10:0] obs_first, obs_last, obs_prev, obs_max;

   find_best_hop_if bus ();

   find_best_hop #(.NBR_BASE(NBR_BASE), .MAX_NBR(MAX_NBR), .NONE_ID(NONE_ID)) dut (
      .clock (clock),
      .rst   (rst),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Memory: read data registered one edge after the address, so the DUT sees it on the second edge.
   always @(posedge clock) bus.data_in <= mem[bus.address];

   initial begin
      #300000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic clear_mem();
      for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
   endtask

   task automatic set_entry(input int i, input logic [15:0] id, input logic [15:0] cl,
                            input logic [15:0] q, input logic [15:0] role);
      mem[int'(NBR_BASE) + 4*i + 0] = id;
      mem[int'(NBR_BASE) + 4*i + 1] = cl;
      mem[int'(NBR_BASE) + 4*i + 2] = q;
      mem[int'(NBR_BASE) + 4*i + 3] = role;
   endtask

   function automatic exp_t model(input int cnt);
      exp_t r;
      int n;
      logic [15:0] id, cl, q, role;
      n = (cnt > MAX_NBR) ? MAX_NBR : cnt;
      r.nh = NONE_ID; r.ns = NONE_ID; r.bq = 16'd0;
      r.lat = (n == 0) ? 1 : 4*n + 3;
      for (int i = 0; i < n; i++) begin
         id   = mem[int'(NBR_BASE) + 4*i + 0];
         cl   = mem[int'(NBR_BASE) + 4*i + 1];
         q    = mem[int'(NBR_BASE) + 4*i + 2];
         role = mem[int'(NBR_BASE) + 4*i + 3];
         if (id == NONE_ID || id == bus.my_id) continue;
         if (q > bus.my_q && q > r.bq) begin r.nh = id; r.bq = q; end
         if (r.ns == NONE_ID && cl == bus.my_cluster && role[0]) r.ns = id;
      end
      return r;
   endfunction

   // Launch one scan and record what the DUT does until done (k = edges after E0).
   task automatic do_scan(input bit pulse);
      int k;
      logic [10:0] prev;
      obs_timeout = 1'b0; obs_steps = 0; obs_jumps = 0; obs_lat = -1;
      obs_busy_all = 1'b1; obs_max = 11'd0;
      @(negedge clock);
      obs_prev  = bus.address;
      obs_first = bus.address;
      bus.start = 1'b1;
      @(posedge clock);
      k = -1;
      prev = obs_prev;
      forever begin
         @(negedge clock);
         k++;
         if (k == 1) obs_first = bus.address;
         if (k >= 2) begin
            if (bus.address == prev + 11'd1) obs_steps++;
            else if (bus.address != prev) obs_jumps++;
         end
         if (k >= 1 && bus.address > obs_max) obs_max = bus.address;
         prev = bus.address;
         if (bus.done) begin obs_lat = k; bus.start = 1'b0; break; end
         if (!bus.busy) obs_busy_all = 1'b0;
         bus.start = pulse;
         if (k >= MAXC) begin obs_timeout = 1'b1; bus.start = 1'b0; break; end
      end
      obs_last = bus.address;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checks++; if (bus.address !== 11'd0) begin failures++; $display("FAIL reset_address got=%h exp=000", bus.address); end
      checks++; if (bus.nexthop !== NONE_ID) begin failures++; $display("FAIL reset_nexthop got=%h exp=%h", bus.nexthop, NONE_ID); end
      checks++; if (bus.nextsinks !== NONE_ID) begin failures++; $display("FAIL reset_nextsinks got=%h exp=%h", bus.nextsinks, NONE_ID); end
      checks++; if (bus.best_q !== 16'd0) begin failures++; $display("FAIL reset_best_q got=%h exp=0000", bus.best_q); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      rst = 1'b0;
   endtask

   task automatic test_empty();
      clear_mem();
      set_entry(0, 16'd11, 16'd2, 16'd90, 16'd1);
      bus.neighbor_count = 8'd0;
      sb.push_back(model(0));
      do_scan(1'b0);
      e = sb.pop_front();
      checks++; if (obs_timeout !== 1'b0) begin failures++; $display("FAIL empty_timeout done not seen in %0d cycles", MAXC); end
      checks++; if (obs_lat !== 1) begin failures++; $display("FAIL empty_latency got=%0d exp=1", obs_lat); end
      checks++; if (bus.nexthop !== e.nh) begin failures++; $display("FAIL empty_nexthop got=%h exp=%h", bus.nexthop, e.nh); end
      checks++; if (bus.nextsinks !== e.ns) begin failures++; $display("FAIL empty_nextsinks got=%h exp=%h", bus.nextsinks, e.ns); end
      checks++; if (bus.best_q !== e.bq) begin failures++; $display("FAIL empty_best_q got=%h exp=%h", bus.best_q, e.bq); end
      checks++; if (obs_last !== obs_prev) begin failures++; $display("FAIL empty_address got=%h exp=%h", obs_last, obs_prev); end
      checks++; if (obs_busy_all !== 1'b1) begin failures++; $display("FAIL empty_busy got=%b exp=1", obs_busy_all); end
   endtask

   task automatic test_best_q();
      clear_mem();
      set_entry(0, 16'd11, 16'd9, 16'd10, 16'd0);
      set_entry(1, 16'd12, 16'd9, 16'd40, 16'd0);
      set_entry(2, 16'd13, 16'd9, 16'd40, 16'd0);
      bus.my_q = 16'd5;
      bus.neighbor_count = 8'd3;
      sb.push_back(model(3));
      do_scan(1'b0);
      e = sb.pop_front();
      checks++; if (obs_timeout !== 1'b0) begin failures++; $display("FAIL best_timeout done not seen in %0d cycles", MAXC); end
      checks++; if (obs_lat !== e.lat) begin failures++; $display("FAIL best_latency got=%0d exp=%0d", obs_lat, e.lat); end
      checks++; if (obs_lat !== 15) begin failures++; $display("FAIL best_latency15 got=%0d exp=15", obs_lat); end
      checks++; if (bus.nexthop !== 16'd12) begin failures++; $display("FAIL best_nexthop got=%h exp=000c", bus.nexthop); end
      checks++; if (bus.nextsinks !== e.ns) begin failures++; $display("FAIL best_nextsinks got=%h exp=%h", bus.nextsinks, e.ns); end
      checks++; if (bus.best_q !== 16'd40) begin failures++; $display("FAIL best_best_q got=%h exp=0028", bus.best_q); end
      checks++; if (obs_first !== NBR_BASE) begin failures++; $display("FAIL best_first_addr got=%h exp=%h", obs_first, NBR_BASE); end
      checks++; if (obs_steps !== 11 || obs_jumps !== 0) begin failures++; $display("FAIL best_addr_seq steps=%0d jumps=%0d exp 11/0", obs_steps, obs_jumps); end
      checks++; if (obs_last !== NBR_BASE + 11'd11) begin failures++; $display("FAIL best_last_addr got=%h exp=%h", obs_last, NBR_BASE + 11'd11); end
      checks++; if (obs_busy_all !== 1'b1) begin failures++; $display("FAIL best_busy got=%b exp=1", obs_busy_all); end
   endtask

   task automatic test_sink_self();
      clear_mem();
      set_entry(0, 16'd7,  16'd2, 16'd20,  16'd1);
      set_entry(1, 16'd3,  16'd2, 16'd99,  16'd1);
      set_entry(2, NONE_ID, 16'd2, 16'd500, 16'd1);
      for (int pass = 0; pass < 2; pass++) begin
         bus.my_q = (pass == 0) ? 16'd5 : 16'd30;
         bus.neighbor_count = (pass == 0) ? 8'd2 : 8'd3;
         sb.push_back(model(int'(bus.neighbor_count)));
         do_scan(1'b0);
         e = sb.pop_front();
         checks++; if (obs_timeout !== 1'b0) begin failures++; $display("FAIL sink%0d_timeout done not seen", pass); end
         checks++; if (obs_lat !== e.lat) begin failures++; $display("FAIL sink%0d_latency got=%0d exp=%0d", pass, obs_lat, e.lat); end
         checks++; if (bus.nexthop !== e.nh) begin failures++; $display("FAIL sink%0d_nexthop got=%h exp=%h", pass, bus.nexthop, e.nh); end
         checks++; if (bus.nextsinks !== 16'd7) begin failures++; $display("FAIL sink%0d_nextsinks got=%h exp=0007", pass, bus.nextsinks); end
         checks++; if (bus.best_q !== e.bq) begin failures++; $display("FAIL sink%0d_best_q got=%h exp=%h", pass, bus.best_q, e.bq); end
      end
   endtask

   task automatic test_clamp();
      clear_mem();
      for (int i = 0; i < 32; i++) set_entry(i, 16'(100 + i), 16'd5, 16'((i * 7) % 50 + 1), 16'd0);
      set_entry(20, 16'd120, 16'd2, 16'd3, 16'd1);
      for (int i = 32; i < 40; i++) set_entry(i, 16'(200 + i), 16'd2, 16'hFFFF, 16'd1);
      bus.my_q = 16'd5;
      bus.neighbor_count = 8'd40;
      sb.push_back(model(40));
      do_scan(1'b0);
      e = sb.pop_front();
      checks++; if (obs_timeout !== 1'b0) begin failures++; $display("FAIL clamp_timeout done not seen in %0d cycles", MAXC); end
      checks++; if (obs_lat !== 131) begin failures++; $display("FAIL clamp_latency got=%0d exp=131", obs_lat); end
      checks++; if (bus.nexthop !== e.nh) begin failures++; $display("FAIL clamp_nexthop got=%h exp=%h", bus.nexthop, e.nh); end
      checks++; if (bus.nextsinks !== 16'd120) begin failures++; $display("FAIL clamp_nextsinks got=%h exp=0078", bus.nextsinks); end
      checks++; if (bus.best_q !== e.bq) begin failures++; $display("FAIL clamp_best_q got=%h exp=%h", bus.best_q, e.bq); end
      checks++; if (obs_max !== NBR_BASE + 11'd127) begin failures++; $display("FAIL clamp_max_addr got=%h exp=%h", obs_max, NBR_BASE + 11'd127); end
      checks++; if (obs_steps !== 127 || obs_jumps !== 0) begin failures++; $display("FAIL clamp_addr_seq steps=%0d jumps=%0d exp 127/0", obs_steps, obs_jumps); end
   endtask

   task automatic test_mid_reset();
      clear_mem();
      set_entry(0, 16'd21, 16'd2, 16'd100, 16'd1);
      set_entry(1, 16'd22, 16'd4, 16'd200, 16'd0);
      set_entry(2, 16'd23, 16'd2, 16'd50,  16'd1);
      bus.my_q = 16'd5;
      bus.neighbor_count = 8'd3;
      @(negedge clock);
      bus.start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.start = 1'b0;
      repeat (5) @(negedge clock);
      rst = 1'b1;
      @(negedge clock);
      checks++; if (bus.address !== 11'd0) begin failures++; $display("FAIL midrst_address got=%h exp=000", bus.address); end
      checks++; if (bus.nexthop !== NONE_ID) begin failures++; $display("FAIL midrst_nexthop got=%h exp=%h", bus.nexthop, NONE_ID); end
      checks++; if (bus.nextsinks !== NONE_ID) begin failures++; $display("FAIL midrst_nextsinks got=%h exp=%h", bus.nextsinks, NONE_ID); end
      checks++; if (bus.best_q !== 16'd0) begin failures++; $display("FAIL midrst_best_q got=%h exp=0000", bus.best_q); end
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL midrst_flags busy=%b done=%b exp 0/0", bus.busy, bus.done); end
      rst = 1'b0;
      repeat (3) @(negedge clock);
      checks++; if (bus.nexthop !== NONE_ID || bus.address !== 11'd0) begin failures++; $display("FAIL midrst_inflight nexthop=%h address=%h exp %h/000", bus.nexthop, bus.address, NONE_ID); end
      sb.push_back(model(3));
      do_scan(1'b0);
      e = sb.pop_front();
      checks++; if (obs_timeout !== 1'b0) begin failures++; $display("FAIL rerun_timeout done not seen in %0d cycles", MAXC); end
      checks++; if (obs_lat !== e.lat) begin failures++; $display("FAIL rerun_latency got=%0d exp=%0d", obs_lat, e.lat); end
      checks++; if (bus.nexthop !== e.nh) begin failures++; $display("FAIL rerun_nexthop got=%h exp=%h", bus.nexthop, e.nh); end
      checks++; if (bus.nextsinks !== e.ns) begin failures++; $display("FAIL rerun_nextsinks got=%h exp=%h", bus.nextsinks, e.ns); end
      checks++; if (bus.best_q !== e.bq) begin failures++; $display("FAIL rerun_best_q got=%h exp=%h", bus.best_q, e.bq); end
   endtask

   task automatic test_back_to_back();
      clear_mem();
      set_entry(0, 16'd41, 16'd2, 16'd60, 16'd0);
      set_entry(1, 16'd42, 16'd2, 16'd80, 16'd1);
      set_entry(2, 16'd43, 16'd2, 16'd70, 16'd1);
      set_entry(3, 16'd44, 16'd1, 16'd90, 16'd1);
      bus.my_q = 16'd50;
      bus.neighbor_count = 8'd4;
      for (int run = 0; run < 2; run++) begin
         sb.push_back(model(4));
         do_scan(run == 0);
         e = sb.pop_front();
         checks++; if (obs_timeout !== 1'b0) begin failures++; $display("FAIL b2b%0d_timeout done not seen", run); end
         checks++; if (obs_lat !== e.lat) begin failures++; $display("FAIL b2b%0d_latency got=%0d exp=%0d", run, obs_lat, e.lat); end
         checks++; if (bus.nexthop !== 16'd44) begin failures++; $display("FAIL b2b%0d_nexthop got=%h exp=002c", run, bus.nexthop); end
         checks++; if (bus.nextsinks !== 16'd42) begin failures++; $display("FAIL b2b%0d_nextsinks got=%h exp=002a", run, bus.nextsinks); end
         checks++; if (bus.best_q !== e.bq) begin failures++; $display("FAIL b2b%0d_best_q got=%h exp=%h", run, bus.best_q, e.bq); end
         checks++; if (obs_steps !== 15 || obs_jumps !== 0) begin failures++; $display("FAIL b2b%0d_addr_seq steps=%0d jumps=%0d exp 15/0", run, obs_steps, obs_jumps); end
      end
      repeat (2) @(negedge clock);
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin failures++; $display("FAIL b2b_idle busy=%b done=%b exp 0/1", bus.busy, bus.done); end
   endtask

   task automatic test_qmax();
      clear_mem();
      set_entry(0, 16'd30, 16'd9, 16'hFFFF, 16'd0);
      set_entry(1, 16'd31, 16'd9, 16'hFFFE, 16'd0);
      bus.neighbor_count = 8'd2;
      for (int pass = 0; pass < 2; pass++) begin
         bus.my_q = (pass == 0) ? 16'hFFFE : 16'hFFFF;
         sb.push_back(model(2));
         do_scan(1'b0);
         e = sb.pop_front();
         checks++; if (obs_timeout !== 1'b0) begin failures++; $display("FAIL qmax%0d_timeout done not seen", pass); end
         checks++; if (bus.nexthop !== e.nh) begin failures++; $display("FAIL qmax%0d_nexthop got=%h exp=%h", pass, bus.nexthop, e.nh); end
         checks++; if (bus.best_q !== e.bq) begin failures++; $display("FAIL qmax%0d_best_q got=%h exp=%h", pass, bus.best_q, e.bq); end
      end
   endtask

   task automatic test_random();
      int n;
      logic [15:0] id;
      for (int it = 0; it < 4; it++) begin
         clear_mem();
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++) begin
            id = 16'($urandom_range(0, 9));
            if (id == 16'd9) id = NONE_ID;
            set_entry(i, id, 16'($urandom_range(1, 3)), 16'($urandom_range(0, 6)), 16'($urandom_range(0, 1)));
         end
         bus.my_q = 16'($urandom_range(0, 3));
         bus.neighbor_count = 8'(n);
         sb.push_back(model(n));
         do_scan(1'b0);
         e = sb.pop_front();
         checks++; if (obs_timeout !== 1'b0) begin failures++; $display("FAIL rand%0d_timeout done not seen", it); end
         checks++; if (obs_lat !== e.lat) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", it, obs_lat, e.lat); end
         checks++; if (bus.nexthop !== e.nh) begin failures++; $display("FAIL rand%0d_nexthop got=%h exp=%h", it, bus.nexthop, e.nh); end
         checks++; if (bus.nextsinks !== e.ns) begin failures++; $display("FAIL rand%0d_nextsinks got=%h exp=%h", it, bus.nextsinks, e.ns); end
         checks++; if (bus.best_q !== e.bq) begin failures++; $display("FAIL rand%0d_best_q got=%h exp=%h", it, bus.best_q, e.bq); end
      end
   endtask

   initial begin
      bus.start          = 1'b0;
      bus.my_id          = 16'd3;
      bus.my_cluster     = 16'd2;
      bus.my_q           = 16'd5;
      bus.neighbor_count = 8'd0;
      clear_mem();
      test_reset();
      test_empty();
      test_best_q();
      test_sink_self();
      test_clamp();
      test_mid_reset();
      test_back_to_back();
      test_qmax();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
